mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 256 +++++++++++++++++++++++++
 tb/tb_mem_access.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage data-memory access: aligned loads/stores to a word-addressed bus with ack and timeout.
// Latency: NOP 1 cycle; aligned access stalls 2+N cycles; misaligned op faults in 1 cycle with no stall.
module mem_access #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_mem_data,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_mem_op,
  input  logic        mem_we,
  input  logic [4:0]  mem_write_reg,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_req,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_write_data,
  output logic        wb_we,
  output logic [4:0]  wb_write_reg,
  output logic        mem_err,
  output logic [31:0] err_addr
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] ldata_q, ldata_d;
  logic        req_q, req_d;
  logic        dwe_q, dwe_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_reg_q, wb_reg_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        stall_c;

  logic        is_load, is_store, is_mem, misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [7:0]  cnt_inc;

  always_comb begin
    is_load    = (mem_mem_op >= OP_LB) && (mem_mem_op <= OP_LW);
    is_store   = (mem_mem_op >= OP_SB) && (mem_mem_op <= OP_SW);
    is_mem     = is_load || is_store;
    misaligned = 1'b0;
    if ((mem_mem_op == OP_LH) || (mem_mem_op == OP_LHU) || (mem_mem_op == OP_SH))
      misaligned = mem_mem_addr[0];
    else if ((mem_mem_op == OP_LW) || (mem_mem_op == OP_SW))
      misaligned = (mem_mem_addr[1:0] != 2'b00);
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = 32'd0;
    case (mem_mem_op)
      OP_SB: begin
        st_be    = 4'b0001 << mem_mem_addr[1:0];
        st_wdata = {4{mem_mem_data[7:0]}};
      end
      OP_SH: begin
        st_be    = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_mem_data[15:0]}};
      end
      OP_SW: begin
        st_be    = 4'b1111;
        st_wdata = mem_mem_data;
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
      end
    endcase
  end

  // Lane selection uses the live address; it is held stable by the stall.
  always_comb begin
    case (mem_mem_addr[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = mem_mem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_mem_op)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    ldata_d     = ldata_q;
    req_d       = req_q;
    dwe_d       = dwe_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_pc_d     = wb_pc_q;
    wb_data_d   = wb_data_q;
    wb_we_d     = wb_we_q;
    wb_reg_d    = wb_reg_q;
    err_d       = 1'b0;
    err_addr_d  = err_addr_q;
    stall_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem && !misaligned) begin
          stall_c     = 1'b1;
          wb_we_d     = 1'b0;
          state_d     = S_REQ;
          req_d       = 1'b1;
          dwe_d       = is_store;
          be_d        = st_be;
          addr_d      = {mem_mem_addr[31:2], 2'b00};
          wdata_d     = st_wdata;
          cnt_d       = 8'd0;
          timed_out_d = 1'b0;
        end else if (is_mem) begin
          wb_pc_d    = mem_pc;
          wb_reg_d   = mem_write_reg;
          wb_data_d  = mem_write_data;
          wb_we_d    = 1'b0;
          err_d      = 1'b1;
          err_addr_d = mem_mem_addr;
        end else begin
          wb_pc_d   = mem_pc;
          wb_reg_d  = mem_write_reg;
          wb_data_d = mem_write_data;
          wb_we_d   = mem_we;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        wb_we_d = 1'b0;
        // Ack has priority over a timeout expiring in the same cycle.
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          dwe_d   = 1'b0;
          ldata_d = ld_ext;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_CNT) begin
            state_d     = S_DONE;
            req_d       = 1'b0;
            dwe_d       = 1'b0;
            timed_out_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        wb_pc_d   = mem_pc;
        wb_reg_d  = mem_write_reg;
        wb_data_d = is_load ? ldata_q : mem_write_data;
        if (timed_out_q) begin
          wb_we_d    = 1'b0;
          err_d      = 1'b1;
          err_addr_d = mem_mem_addr;
        end else begin
          wb_we_d = mem_we;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      timed_out_q <= 1'b0;
      ldata_q     <= 32'd0;
      req_q       <= 1'b0;
      dwe_q       <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wb_pc_q     <= 32'd0;
      wb_data_q   <= 32'd0;
      wb_we_q     <= 1'b0;
      wb_reg_q    <= 5'd0;
      err_q       <= 1'b0;
      err_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      ldata_q     <= ldata_d;
      req_q       <= req_d;
      dwe_q       <= dwe_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_pc_q     <= wb_pc_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_reg_q    <= wb_reg_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Stall is forced low while reset is held so every output reads zero.
  assign stall_req     = rst & stall_c;
  assign dmem_req      = req_q;
  assign dmem_we       = dwe_q;
  assign dmem_be       = be_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign wb_pc         = wb_pc_q;
  assign wb_write_data = wb_data_q;
  assign wb_we         = wb_we_q;
  assign wb_write_reg  = wb_reg_q;
  assign mem_err       = err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access with a transaction-level reference model.
module tb_mem_access;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc, mem_mem_addr, mem_mem_data, mem_write_data;
  logic [3:0]  mem_mem_op;
  logic        mem_we;
  logic [4:0]  mem_write_reg;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall_req;
  logic [31:0] wb_pc, wb_write_data;
  logic        wb_we;
  logic [4:0]  wb_write_reg;
  logic        mem_err;
  logic [31:0] err_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_pc(mem_pc), .mem_mem_addr(mem_mem_addr), .mem_mem_data(mem_mem_data),
    .mem_write_data(mem_write_data), .mem_mem_op(mem_mem_op), .mem_we(mem_we),
    .mem_write_reg(mem_write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_req(stall_req),
    .wb_pc(wb_pc), .wb_write_data(wb_write_data), .wb_we(wb_we),
    .wb_write_reg(wb_write_reg), .mem_err(mem_err), .err_addr(err_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_dmem_ctl"}, {25'd0, dmem_req, dmem_we, dmem_be, stall_req}, 32'd0);
    check({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_wb_pc"}, wb_pc, 32'd0);
    check({tag, "_wb_data"}, wb_write_data, 32'd0);
    check({tag, "_wb_ctl"}, {25'd0, wb_we, wb_write_reg, mem_err}, 32'd0);
    check({tag, "_err_addr"}, err_addr, 32'd0);
  endtask

  // delay >= 0: ack arrives in REQ cycle delay+1; delay < 0: memory never acks.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] alu, input logic [31:0] pc, input logic we,
                        input logic [4:0] wreg, input logic [31:0] rdata, input int delay);
    bit is_ld, is_st, mis, done;
    int stalls, reqk;
    logic [31:0] exp_be, exp_wd;
    is_ld = (op >= 1) && (op <= 5);
    is_st = (op >= 6) && (op <= 8);
    mis   = ((op == 3 || op == 4 || op == 7) && addr[0]) ||
            ((op == 5 || op == 8) && (addr[1:0] != 2'b00));
    mem_pc = pc; mem_mem_addr = addr; mem_mem_data = sdata; mem_write_data = alu;
    mem_mem_op = op; mem_we = we; mem_write_reg = wreg;
    dmem_ack = 1'b0; dmem_rdata = rdata;
    #1;
    if (!(is_ld || is_st)) begin
      check("nop_stall", stall_req, 0);
      @(negedge clk);
      check("nop_wb_pc", wb_pc, pc);
      check("nop_wb_we", wb_we, we);
      check("nop_wb_reg", wb_write_reg, wreg);
      check("nop_wb_data", wb_write_data, alu);
      check("nop_err", mem_err, 0);
      check("nop_no_req", dmem_req, 0);
    end else if (mis) begin
      check("mis_stall", stall_req, 0);
      @(negedge clk);
      check("mis_no_req", dmem_req, 0);
      check("mis_wb_we", wb_we, 0);
      check("mis_err", mem_err, 1);
      check("mis_err_addr", err_addr, addr);
    end else begin
      check("acc_stall_first", stall_req, 1);
      exp_be = 32'hF;
      exp_wd = 32'd0;
      if (op == 6) begin
        exp_be = 32'd1 << addr[1:0];
        exp_wd = (sdata & 32'hFF) * 32'h01010101;
      end else if (op == 7) begin
        exp_be = addr[1] ? 32'hC : 32'h3;
        exp_wd = (sdata & 32'hFFFF) * 32'h00010001;
      end else if (op == 8) begin
        exp_wd = sdata;
      end
      stalls = 1; reqk = 0; done = 1'b0;
      for (int i = 0; i < TO + 10 && !done; i++) begin
        @(negedge clk);
        if (stall_req) begin
          stalls++; reqk++;
          check("req_vld", dmem_req, 1);
          check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
          check("req_be", dmem_be, exp_be);
          check("req_we", dmem_we, is_st);
          if (is_st) check("req_wdata", dmem_wdata, exp_wd);
          if (reqk == 1) begin
            check("req_bubble_we", wb_we, 0);
            check("req_err_low", mem_err, 0);
          end
          dmem_ack = (delay >= 0) && (reqk == delay + 1);
        end else begin
          done = 1'b1;
        end
      end
      dmem_ack = 1'b0;
      check("acc_done_in_bound", done, 1);
      check("acc_stall_cycles", stalls, (delay >= 0) ? 2 + delay : 1 + TO);
      check("done_req_low", dmem_req, 0);
      @(negedge clk);
      if (delay < 0) begin
        check("tout_wb_we", wb_we, 0);
        check("tout_err", mem_err, 1);
        check("tout_err_addr", err_addr, addr);
      end else begin
        check("acc_wb_we", wb_we, we);
        check("acc_wb_reg", wb_write_reg, wreg);
        check("acc_wb_pc", wb_pc, pc);
        check("acc_wb_data", wb_write_data, is_ld ? model_load(op, addr, rdata) : alu);
        check("acc_err", mem_err, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_pc = '0; mem_mem_addr = '0; mem_mem_data = '0; mem_write_data = '0;
    mem_mem_op = '0; mem_we = 1'b0; mem_write_reg = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(4'd5, 32'h100, 32'h0, 32'h1111, 32'h40, 1'b1, 5'd5, 32'hDEADBEEF, 1);
    run_op(4'd1, 32'h103, 32'h0, 32'h0, 32'h44, 1'b1, 5'd6, 32'h80FFFFFF, 2);
    run_op(4'd2, 32'h103, 32'h0, 32'h0, 32'h48, 1'b1, 5'd7, 32'h80FFFFFF, 1);
    run_op(4'd7, 32'h202, 32'h1234ABCD, 32'h2222, 32'h4C, 1'b0, 5'd0, 32'h0, 1);
    run_op(4'd5, 32'h101, 32'h0, 32'h0, 32'h50, 1'b1, 5'd8, 32'h0, 1);
    run_op(4'd0, 32'h0, 32'h0, 32'hCAFE, 32'h54, 1'b1, 5'd9, 32'h0, 1);
    run_op(4'd8, 32'h300, 32'h55667788, 32'h3333, 32'h58, 1'b0, 5'd0, 32'h0, -1);
    run_op(4'd12, 32'h7, 32'h0, 32'hBEEF, 32'h5C, 1'b1, 5'd10, 32'h0, 1);
    run_op(4'd3, 32'h106, 32'h0, 32'h0, 32'h60, 1'b1, 5'd11, 32'h9ABC1234, 3);
    run_op(4'd4, 32'h105, 32'h0, 32'h0, 32'h64, 1'b1, 5'd12, 32'h0, 1);
    run_op(4'd6, 32'h401, 32'h000000A5, 32'h0, 32'h68, 1'b0, 5'd0, 32'h0, 1);

    mem_pc = 32'h70; mem_mem_addr = 32'h800; mem_mem_op = 4'd5; mem_we = 1'b1;
    mem_write_reg = 5'd3; dmem_ack = 1'b0;
    @(negedge clk);
    check("rstreq_req", dmem_req, 1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid_req");
    @(negedge clk);
    rst = 1'b1;
    run_op(4'd0, 32'h0, 32'h0, 32'h55AA, 32'h500, 1'b1, 5'd7, 32'h0, 1);

    for (int t = 0; t < 200; t++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          d;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      d  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 4));
      run_op(op, a, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
